// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR output path: requantiser FSM states,
// saturating round function and statistics counter width.
package fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROC,
        S_WRITE,
        S_HOLD
    } state_t;

    localparam int unsigned SAT_COUNT_WIDTH = 16;
    localparam int unsigned CALC_W          = 64;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] value;
    } sat_res_t;

    // Round-half-up then arithmetic shift; result clamped to a signed out_w range.
    // The working width is far wider than any sane IN_WIDTH+1, so the bias add cannot overflow.
    function automatic sat_res_t sat_round(input logic signed [CALC_W-1:0] value,
                                           input int unsigned shift,
                                           input int unsigned out_w);
        logic signed [CALC_W-1:0] w_one;
        logic signed [CALC_W-1:0] w_bias;
        logic signed [CALC_W-1:0] w_shifted;
        logic signed [CALC_W-1:0] w_max;
        logic signed [CALC_W-1:0] w_min;
        sat_res_t                 w_res;
        w_one     = 64'sd1;
        w_bias    = (shift == 0) ? '0 : (w_one <<< (shift - 1));
        w_shifted = (value + w_bias) >>> shift;
        w_max     = (w_one <<< (out_w - 1)) - w_one;
        w_min     = -w_max - w_one;
        w_res.sat = 1'b0;
        if (w_shifted > w_max) begin
            w_res.value = w_max;
            w_res.sat   = 1'b1;
        end else if (w_shifted < w_min) begin
            w_res.value = w_min;
            w_res.sat   = 1'b1;
        end else begin
            w_res.value = w_shifted;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head is visible on ov_dout while not empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         iv_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         ov_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   ov_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LW'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign ov_level  = r_level;
    assign ov_dout   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= iv_din;
        end
    end

    // Pointers wrap naturally at a power-of-two depth; level separates full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fir_output_requant_fifo.sv
// FIR output stage: rounds and saturates each accumulator result, buffers it in a
// FWFT FIFO towards the sink and keeps saturation statistics.
module fir_output_requant_fifo
    import fir_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [IN_WIDTH-1:0]          iv_din,
    input  logic                         i_din_valid,
    output logic                         o_ack,
    output logic [OUT_WIDTH-1:0]         ov_dout,
    output logic                         o_dout_valid,
    input  logic                         i_ready,
    output logic [$clog2(FIFO_DEPTH):0]  ov_level,
    output logic                         o_sat_flag,
    input  logic                         i_sat_clr,
    output logic [SAT_COUNT_WIDTH-1:0]   ov_sat_count
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t                       r_state;
    logic signed [IN_WIDTH-1:0]   r_din;
    logic [OUT_WIDTH-1:0]         r_res;
    logic                         r_sat;
    logic                         r_ack;
    logic                         r_sat_flag;
    logic [SAT_COUNT_WIDTH-1:0]   r_sat_count;

    sat_res_t                     w_rq;
    logic [OUT_WIDTH-1:0]         w_rq_val;
    logic [CALC_W-OUT_WIDTH-1:0]  w_rq_unused;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_empty;
    logic                         w_full;
    logic [LVL_W-1:0]             w_level;

    always_comb begin
        w_rq = sat_round(CALC_W'(r_din), SHIFT, OUT_WIDTH);
        {w_rq_unused, w_rq_val} = w_rq.value;
    end

    assign w_push = (r_state == S_WRITE);
    assign w_pop  = !w_empty && i_ready;

    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_push),
        .iv_din   (r_res),
        .i_pop    (w_pop),
        .ov_dout  (ov_dout),
        .o_empty  (w_empty),
        .o_full   (w_full),
        .ov_level (w_level)
    );

    // o_ack is set on the PROC->WRITE transition so it is high exactly during S_WRITE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_din       <= '0;
            r_res       <= '0;
            r_sat       <= 1'b0;
            r_ack       <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_din_valid && !w_full) begin
                        r_din   <= iv_din;
                        r_state <= S_PROC;
                    end
                end
                S_PROC: begin
                    r_res   <= w_rq_val;
                    r_sat   <= w_rq.sat;
                    r_ack   <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: r_state <= S_HOLD;
                S_HOLD:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // A clear in the same cycle as a saturating write discards that event.
            if (i_sat_clr) begin
                r_sat_flag  <= 1'b0;
                r_sat_count <= '0;
            end else if (r_state == S_WRITE && r_sat) begin
                r_sat_flag <= 1'b1;
                if (r_sat_count != '1) begin
                    r_sat_count <= r_sat_count + SAT_COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign o_ack        = r_ack;
    assign o_dout_valid = !w_empty;
    assign ov_level     = w_level;
    assign o_sat_flag   = r_sat_flag;
    assign ov_sat_count = r_sat_count;

endmodule

// File: tb/tb_fir_output_requant_fifo.sv
// Self-checking bench for fir_output_requant_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fir_output_requant_fifo;

    localparam int IN_W  = 24;
    localparam int OUT_W = 16;
    localparam int SHIFT = 8;
    localparam int DEPTH = 8;

    logic              clk;
    logic              i_rst;
    logic [IN_W-1:0]   iv_din;
    logic              i_din_valid;
    logic              o_ack;
    logic [OUT_W-1:0]  ov_dout;
    logic              o_dout_valid;
    logic              i_ready;
    logic [3:0]        ov_level;
    logic              o_sat_flag;
    logic              i_sat_clr;
    logic [15:0]       ov_sat_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pops = 0;
    bit mon_en = 0;

    logic [OUT_W-1:0] model_q[$];
    logic             m_flag;
    logic [15:0]      m_cnt;
    logic [OUT_W-1:0] m_e;
    bit               m_s;

    fir_output_requant_fifo #(
        .IN_WIDTH   (IN_W),
        .OUT_WIDTH  (OUT_W),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .iv_din       (iv_din),
        .i_din_valid  (i_din_valid),
        .o_ack        (o_ack),
        .ov_dout      (ov_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready),
        .ov_level     (ov_level),
        .o_sat_flag   (o_sat_flag),
        .i_sat_clr    (i_sat_clr),
        .ov_sat_count (ov_sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact floor((x + 2^(S-1)) / 2^S) with signed integers, then clamp.
    function automatic logic [OUT_W-1:0] ref_q(input logic [IN_W-1:0] x, output bit sat);
        longint v, d, q, hi, lo;
        v = longint'($signed(x));
        d = longint'(1) << SHIFT;
        if (SHIFT > 0) v = v + d / 2;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        sat = 1'b0;
        if (q > hi) begin
            q = hi;
            sat = 1'b1;
        end else if (q < lo) begin
            q = lo;
            sat = 1'b1;
        end
        return q[OUT_W-1:0];
    endfunction

    // Monitor: compares state observed this cycle, then applies the handshakes
    // that will take effect at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i_rst) begin
                model_q.delete();
                m_flag = 1'b0;
                m_cnt  = '0;
            end else begin
                check("level", ov_level, model_q.size());
                check("dout_valid", o_dout_valid, model_q.size() != 0);
                check("sat_flag", o_sat_flag, m_flag);
                check("sat_count", ov_sat_count, m_cnt);
                if (o_dout_valid && i_ready && model_q.size() > 0) begin
                    check("dout_order", ov_dout, model_q[0]);
                    void'(model_q.pop_front());
                    n_pops++;
                end
                if (o_ack) begin
                    m_e = ref_q(iv_din, m_s);
                    model_q.push_back(m_e);
                    if (!i_sat_clr && m_s) begin
                        m_flag = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                end
                if (i_sat_clr) begin
                    m_flag = 1'b0;
                    m_cnt  = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds valid until o_ack, then waits out S_HOLD so the DUT is back in S_IDLE.
    task automatic send_one(input logic [IN_W-1:0] x, input bit rnd);
        bit got;
        got = 1'b0;
        iv_din      = x;
        i_din_valid = 1'b1;
        for (int c = 0; c < 80 && !got; c++) begin
            tick();
            if (rnd) begin
                i_ready   = 1'($urandom_range(0, 1));
                i_sat_clr = ($urandom_range(0, 15) == 0);
            end
            if (o_ack) got = 1'b1;
        end
        i_din_valid = 1'b0;
        check("ack_seen", got, 1);
        for (int c = 0; c < 2; c++) begin
            tick();
            if (rnd) begin
                i_ready   = 1'($urandom_range(0, 1));
                i_sat_clr = 1'b0;
            end
        end
        i_sat_clr = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (o_ack) got = 1'b1;
            else tick();
        end
        check(name, got, 1);
    endtask

    typedef struct {
        logic [IN_W-1:0]  din;
        logic [OUT_W-1:0] dout;
        logic             flag;
        logic [15:0]      cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int pops0;
        logic [IN_W-1:0] x;
        logic [10:0] r;

        tbl[0] = '{24'h000180, 16'h0002, 1'b0, 16'd0};
        tbl[1] = '{24'h00017F, 16'h0001, 1'b0, 16'd0};
        tbl[2] = '{24'hFFFE80, 16'hFFFF, 1'b0, 16'd0};
        tbl[3] = '{24'h7FFF7F, 16'h7FFF, 1'b0, 16'd0};
        tbl[4] = '{24'h7FFF80, 16'h7FFF, 1'b1, 16'd1};
        tbl[5] = '{24'h800000, 16'h8000, 1'b1, 16'd1};

        i_rst = 1'b1;
        iv_din = '0;
        i_din_valid = 1'b0;
        i_ready = 1'b0;
        i_sat_clr = 1'b0;
        m_flag = 1'b0;
        m_cnt = '0;
        repeat (3) tick();
        check("rst_ack", o_ack, 0);
        check("rst_dout", ov_dout, 0);
        check("rst_dout_valid", o_dout_valid, 0);
        check("rst_level", ov_level, 0);
        check("rst_sat_flag", o_sat_flag, 0);
        check("rst_sat_count", ov_sat_count, 0);
        i_rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Vector table: each result parked at the FIFO head, checked, then popped.
        for (int i = 0; i < 6; i++) begin
            i_ready = 1'b0;
            send_one(tbl[i].din, 1'b0);
            check("tbl_dout", ov_dout, tbl[i].dout);
            check("tbl_flag", o_sat_flag, tbl[i].flag);
            check("tbl_count", ov_sat_count, tbl[i].cnt);
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            check("tbl_level_after_pop", ov_level, 0);
        end

        // Latency: valid in cycle N, ack in N+2, output in N+3, drained in N+4.
        i_ready = 1'b1;
        iv_din = 24'h001234;
        i_din_valid = 1'b1;
        tick();
        check("lat_ack_n1", o_ack, 0);
        check("lat_valid_n1", o_dout_valid, 0);
        tick();
        check("lat_ack_n2", o_ack, 1);
        check("lat_valid_n2", o_dout_valid, 0);
        i_din_valid = 1'b0;
        tick();
        check("lat_ack_n3", o_ack, 0);
        check("lat_valid_n3", o_dout_valid, 1);
        check("lat_dout_n3", ov_dout, 16'h0012);
        check("lat_level_n3", ov_level, 1);
        tick();
        check("lat_level_n4", ov_level, 0);

        // Backpressure: eight fill the FIFO, the ninth stalls without an ack.
        i_ready = 1'b0;
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) send_one(24'h000100 * (i + 1), 1'b0);
        check("bp_level_full", ov_level, 8);
        iv_din = 24'h000900;
        i_din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bp_no_ack", o_ack, 0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        wait_ack("bp_ninth_ack");
        i_din_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 40 && ov_level != 0; c++) tick();
        repeat (2) tick();
        check("bp_drained_level", ov_level, 0);
        check("bp_drained_count", n_pops - pops0, 9);

        // Push and pop in the same cycle at level 3.
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_one(24'h001000 + 24'(i), 1'b0);
        check("pp_level_before", ov_level, 3);
        iv_din = 24'h002000;
        i_din_valid = 1'b1;
        wait_ack("pp_ack");
        i_din_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("pp_level_after", ov_level, 3);
        tick();
        i_ready = 1'b1;
        repeat (6) tick();

        // Clear coincident with a saturating write: clear wins, event lost.
        send_one(24'h7FFF80, 1'b0);
        check("clr_flag_pre", o_sat_flag, 1);
        iv_din = 24'h7FFFFF;
        i_din_valid = 1'b1;
        wait_ack("clr_ack");
        i_din_valid = 1'b0;
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("clr_flag", o_sat_flag, 0);
        check("clr_count", ov_sat_count, 0);
        repeat (3) tick();

        // Reset while a sample is in S_PROC with four queued.
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_one(24'h003000 + 24'(i), 1'b0);
        check("rm_level_before", ov_level, 4);
        iv_din = 24'h7FFFFF;
        i_din_valid = 1'b1;
        tick();
        check("rm_ack_proc", o_ack, 0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_din_valid = 1'b0;
        check("rm_level", ov_level, 0);
        check("rm_dout_valid", o_dout_valid, 0);
        check("rm_ack", o_ack, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rm_no_ack", o_ack, 0);
        end

        // Randomized traffic with random sink stalls and occasional clears.
        for (int i = 0; i < 200; i++) begin
            r = 11'($urandom());
            case ($urandom_range(0, 3))
                0: x = 24'($urandom());
                1: x = 24'h7FFF80 + 24'($urandom_range(0, 6)) - 24'd3;
                2: x = 24'h800000 + 24'($urandom_range(0, 300));
                default: x = {{13{r[10]}}, r};
            endcase
            repeat ($urandom_range(0, 2)) tick();
            send_one(x, 1'b1);
        end
        i_ready = 1'b1;
        i_sat_clr = 1'b0;
        repeat (20) tick();
        check("final_level", ov_level, 0);
        check("final_queue", model_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fir_output_requant_fifo.md
Name: fir_output_requant_fifo

Overview:
- Downstream stage of the FIR MAC engine.
- Accepts one full-width accumulator result per handshake from the filter and rounds it (round-half-up, arithmetic shift).
- Saturates the result to the output width and buffers it in a small first-word-fall-through FIFO.
- Presents samples to the DAC/stream sink on a valid/ready interface and tracks saturation events for software.

Parameters:
- IN_WIDTH, 24, width of the signed FIR result
- OUT_WIDTH, 16, width of the signed output sample
- SHIFT, 8, right-shift applied before saturation; 0 = no rounding; must be < IN_WIDTH
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- iv_din  in  IN_WIDTH  signed FIR result
- i_din_valid  in  1  upstream result valid; held until o_ack
- o_ack  out  1  one-cycle pulse: result consumed
- ov_dout  out  OUT_WIDTH  signed requantised sample (FIFO head)
- o_dout_valid  out  1  FIFO not empty
- i_ready  in  1  sink accepts ov_dout this cycle
- ov_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_sat_flag  out  1  sticky: saturation occurred
- i_sat_clr  in  1  clears o_sat_flag and ov_sat_count
- ov_sat_count  out  16  saturation event counter

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk.
  - On reset: o_ack=0, o_dout_valid=0, ov_dout=0, ov_level=0, o_sat_flag=0, ov_sat_count=0, FSM=S_IDLE, FIFO pointers=0.
  - Reset mid-operation discards the in-flight sample and all FIFO contents; no o_ack is issued for a discarded sample.
- FSM states:
  - S_IDLE: if i_din_valid && ov_level < FIFO_DEPTH, register iv_din -> S_PROC; else stay.
  - S_PROC: add 2^(SHIFT-1) (skip if SHIFT=0) in IN_WIDTH+1 bits, arithmetic shift right SHIFT, compare against OUT range, register result and sat bit -> S_WRITE.
  - S_WRITE: push result into FIFO, o_ack=1 this cycle only, update saturation stats -> S_HOLD.
  - S_HOLD: one dead cycle, ignore i_din_valid (upstream drops or replaces valid within this cycle) -> S_IDLE.
- Latency: valid sampled in S_IDLE at cycle N; o_ack high in cycle N+2; with the FIFO empty, o_dout_valid=1 and the sample on ov_dout in cycle N+3. Minimum spacing between accepted inputs is 4 cycles.
- Saturation:
  - value > 2^(OUT_WIDTH-1)-1 -> max positive; value < -2^(OUT_WIDTH-1) -> min negative.
  - Either case sets o_sat_flag and increments ov_sat_count.
  - ov_sat_count sticks at 0xFFFF (no wrap).
  - i_sat_clr in the same cycle as a saturation event: clear wins, and the event is lost.
- FIFO:
  - Pop when o_dout_valid && i_ready; ov_dout shows the head combinationally from registered storage.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - Full is checked only in S_IDLE. Pops during S_PROC/S_WRITE only free space, so S_WRITE never overflows.
  - A pop on empty is ignored. Pointers wrap modulo FIFO_DEPTH; level is tracked separately to distinguish full from empty.
- Backpressure: while the FIFO is full, the block stays in S_IDLE and withholds o_ack, stalling the filter upstream.

Decomposition:
- Shared package fir_pkg:
  - FSM state encoding (S_IDLE, S_PROC, S_WRITE, S_HOLD)
  - function sat_round(value, SHIFT, OUT_WIDTH) returning {sat, result}
  - SAT_COUNT_WIDTH=16 constant
- One sub-module: sync_fifo_fwft (WIDTH, DEPTH), providing push, pop, dout, empty, full and level. It is reused later for the input sample path.

Test Plan:
- Rounding, SHIFT=8: inputs 0x000180, 0x00017F, 0xFFFE80 -> outputs 0x0002, 0x0001, 0xFFFF (-1); o_sat_flag stays 0.
- Saturation boundary: 0x7FFF7F -> 0x7FFF, no flag. Then 0x7FFF80 -> 0x7FFF, o_sat_flag=1, ov_sat_count=1. Then 0x800000 -> 0x8000, count unchanged.
- Latency and ack: single valid at cycle N with i_ready=1 -> o_ack only at N+2, o_dout_valid at N+3, ov_level back to 0 at N+4.
- Backpressure: i_ready=0, push 9 samples with FIFO_DEPTH=8 -> 8 acks, ov_level=8, 9th held with no o_ack. Raise i_ready for 1 cycle -> 9th accepted, all 9 drain in order.
- Simultaneous push/pop at level 3 -> level stays 3. i_sat_clr coincident with a saturating sample -> flag=0, count=0.
- Reset mid-operation: assert i_rst in S_PROC with 4 samples queued -> next cycle ov_level=0, o_dout_valid=0, o_ack never pulses for the in-flight sample.
